// File: rtl/std_mem_arbiter.sv
// std_mem_arbiter: round-robin share of one std_mem_double port among NUM_REQ requesters
module std_mem_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int MASK_WIDTH     = DATA_WIDTH / 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_read_enable,
    input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_write_enable,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             mem_cmd_valid,
    input  logic                             mem_cmd_ready,
    output logic                             mem_cmd_read_enable,
    output logic [MASK_WIDTH-1:0]            mem_cmd_write_enable,
    output logic [ADDR_WIDTH-1:0]            mem_cmd_addr,
    output logic [DATA_WIDTH-1:0]            mem_cmd_data,
    input  logic                             mem_rsp_valid,
    output logic                             mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    output logic [CW-1:0]                    outstanding,
    output logic                             err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic [IW-1:0]      ptr, locked_id, g, h;
    logic               lock, found, accept, push, pop, nonempty, full;
    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      fifo [MAX_OUTSTANDING];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    int                 idx;

    assign full     = count == CW'(MAX_OUTSTANDING);
    assign nonempty = count != '0;
    assign h        = fifo[rd_ptr];
    assign elig     = req_valid & ~(req_read_enable & {NUM_REQ{full}});

    // round-robin scan from ptr; a stalled command keeps its grant
    always_comb begin
        g = locked_id;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                g = IW'(idx);
            end
        end
        if (lock) g = locked_id;
    end

    assign mem_cmd_valid        = !rst && (found || lock);
    assign mem_cmd_read_enable  = req_read_enable[g];
    assign mem_cmd_write_enable = req_write_enable[g*MASK_WIDTH +: MASK_WIDTH];
    assign mem_cmd_addr         = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_cmd_data         = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign accept               = mem_cmd_valid && mem_cmd_ready;
    assign push                 = accept && mem_cmd_read_enable;
    assign mem_rsp_ready        = !rst && nonempty && rsp_ready[h];
    assign pop                  = mem_rsp_valid && mem_rsp_ready;
    assign rsp_data             = mem_rsp_data;
    assign outstanding          = count;

    // one-hot lane steering for command ready and result valid
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (g == IW'(i));
            rsp_valid[i] = !rst && mem_rsp_valid && nonempty && (h == IW'(i));
        end
    end

    // arbitration state: advance priority on accept, lock grant on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            lock      <= 1'b0;
            locked_id <= '0;
        end else if (accept) begin
            ptr  <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            lock <= 1'b0;
        end else if (mem_cmd_valid) begin
            lock      <= 1'b1;
            locked_id <= g;
        end
    end

    // ID FIFO pointers and occupancy; power-of-2 depth wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // ID storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= g;
    end

    // sticky protocol error: a result arrived with no read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (mem_rsp_valid && !nonempty) err <= 1'b1;
    end
endmodule
